// File: rtl/servo_pwm_capture.sv
// rtl/servo_pwm_capture.sv - servo pulse width/period capture with Avalon-MM registers
module servo_pwm_capture #(
  parameter int TICK_DIV     = 50,
  parameter int MIN_PULSE_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int TIMEOUT_US   = 25000,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  output logic [31:0]      readdata,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic             irq,
  output logic [CNT_W-1:0] pulse_us,
  output logic             pulse_valid
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(MIN_PULSE_US);
  localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(MAX_PULSE_US);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_US);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_t;

  logic             sync1_q, sync2_q, level_q;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [PW-1:0]    presc_q, presc_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d, period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] width_hold_q, width_hold_d, pulse_us_q, pulse_us_d;
  logic [CNT_W-1:0] period_reg_q, period_reg_d;
  logic             pulse_valid_q, pulse_valid_d, new_sample_q, new_sample_d;
  logic             range_err_q, range_err_d, signal_lost_q, signal_lost_d;
  logic             irq_en_q, irq_en_d, cap_en_q, cap_en_d;
  logic             tick, wr_status, wr_ctrl;
  logic [CNT_W-1:0] width_inc, period_inc;
  logic             unused_wdata;

  // Synchronizer carries no reset so a pulse already high across reset never looks like a rise.
  always_ff @(posedge clk) begin
    sync1_q <= pwm_in;
    sync2_q <= sync1_q;
    level_q <= sync2_q;
  end

  always_comb begin
    rise_d     = sync2_q & ~level_q;
    fall_d     = ~sync2_q & level_q;
    tick       = (presc_q == PRESC_LAST);
    presc_d    = (rise_q || tick) ? '0 : presc_q + 1'b1;
    width_inc  = (tick && width_cnt_q != CNT_MAX) ? width_cnt_q + 1'b1 : width_cnt_q;
    period_inc = (tick && period_cnt_q != CNT_MAX) ? period_cnt_q + 1'b1 : period_cnt_q;
    wr_status  = chipselect && write && (address == 2'd2);
    wr_ctrl    = chipselect && write && (address == 2'd3);

    state_d       = state_q;
    width_cnt_d   = width_cnt_q;
    period_cnt_d  = period_cnt_q;
    width_hold_d  = width_hold_q;
    pulse_us_d    = pulse_us_q;
    period_reg_d  = period_reg_q;
    pulse_valid_d = pulse_valid_q;
    irq_en_d      = wr_ctrl ? writedata[0] : irq_en_q;
    cap_en_d      = wr_ctrl ? writedata[1] : cap_en_q;
    // Clears are applied first so a same-cycle set below wins.
    new_sample_d  = new_sample_q & ~(wr_status & writedata[1]);
    range_err_d   = range_err_q & ~(wr_status & writedata[2]);
    signal_lost_d = signal_lost_q & ~(wr_status & writedata[3]);

    if (!cap_en_q) begin
      state_d      = ST_IDLE;
      width_cnt_d  = '0;
      period_cnt_d = '0;
    end else if (state_q != ST_IDLE && period_cnt_q >= TIMEOUT_C) begin
      state_d       = ST_IDLE;
      width_cnt_d   = '0;
      period_cnt_d  = '0;
      signal_lost_d = 1'b1;
      pulse_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          width_cnt_d  = '0;
          period_cnt_d = '0;
          if (rise_q) state_d = ST_HIGH;
        end
        ST_HIGH: begin
          width_cnt_d  = width_inc;
          period_cnt_d = period_inc;
          if (fall_q) begin
            width_hold_d = width_inc;
            state_d      = ST_LOW;
          end
        end
        ST_LOW: begin
          period_cnt_d = period_inc;
          if (rise_q) begin
            if (width_hold_q >= MIN_W && width_hold_q <= MAX_W) begin
              pulse_us_d    = width_hold_q;
              period_reg_d  = period_inc;
              pulse_valid_d = 1'b1;
              new_sample_d  = 1'b1;
            end else begin
              range_err_d = 1'b1;
            end
            width_cnt_d  = '0;
            period_cnt_d = '0;
            state_d      = ST_HIGH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      presc_q       <= '0;
      state_q       <= ST_IDLE;
      width_cnt_q   <= '0;
      period_cnt_q  <= '0;
      width_hold_q  <= '0;
      pulse_us_q    <= '0;
      period_reg_q  <= '0;
      pulse_valid_q <= 1'b0;
      new_sample_q  <= 1'b0;
      range_err_q   <= 1'b0;
      signal_lost_q <= 1'b0;
      irq_en_q      <= 1'b0;
      cap_en_q      <= 1'b1;
    end else begin
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      presc_q       <= presc_d;
      state_q       <= state_d;
      width_cnt_q   <= width_cnt_d;
      period_cnt_q  <= period_cnt_d;
      width_hold_q  <= width_hold_d;
      pulse_us_q    <= pulse_us_d;
      period_reg_q  <= period_reg_d;
      pulse_valid_q <= pulse_valid_d;
      new_sample_q  <= new_sample_d;
      range_err_q   <= range_err_d;
      signal_lost_q <= signal_lost_d;
      irq_en_q      <= irq_en_d;
      cap_en_q      <= cap_en_d;
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      case (address)
        2'd0:    readdata = 32'(pulse_us_q);
        2'd1:    readdata = 32'(period_reg_q);
        2'd2:    readdata = {28'd0, signal_lost_q, range_err_q, new_sample_q, pulse_valid_q};
        default: readdata = {30'd0, cap_en_q, irq_en_q};
      endcase
    end
  end

  assign irq          = irq_en_q & (new_sample_q | range_err_q | signal_lost_q);
  assign pulse_us     = pulse_us_q;
  assign pulse_valid  = pulse_valid_q;
  assign unused_wdata = ^writedata[31:4];
endmodule

// File: tb/tb_servo_pwm_capture.sv
// tb/tb_servo_pwm_capture.sv - self-checking bench for servo_pwm_capture (scaled timing)
module tb_servo_pwm_capture;
  localparam int D    = 4;
  localparam int MINP = 50;
  localparam int MAXP = 250;
  localparam int TOUT = 2500;

  logic        clk = 1'b0;
  logic        reset, pwm_in, chipselect, read, write;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq, pulse_valid;
  logic [15:0] pulse_us;

  servo_pwm_capture #(
    .TICK_DIV(D), .MIN_PULSE_US(MINP), .MAX_PULSE_US(MAXP), .TIMEOUT_US(TOUT), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .pwm_in(pwm_in), .address(address), .chipselect(chipselect),
    .read(read), .readdata(readdata), .write(write), .writedata(writedata), .irq(irq),
    .pulse_us(pulse_us), .pulse_valid(pulse_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit m_en, m_irq_en, m_ref, m_valid, m_new, m_range, m_lost;
  int m_pulse, m_period, m_rise_c, m_fall_c;
  logic [31:0] last_status;
  logic        last_irq;

  typedef struct {
    int high_us;
    int low_us;
    int exp_pulse;
    int exp_period;
    int exp_status;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0; read = 1'b0; address = 2'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; address = 2'd0;
  endtask

  task automatic model_reset();
    m_en = 1; m_irq_en = 0; m_ref = 0; m_valid = 0; m_new = 0; m_range = 0; m_lost = 0;
    m_pulse = 0; m_period = 0; m_rise_c = 0; m_fall_c = 0;
  endtask

  task automatic model_ctrl(input logic [31:0] v);
    m_irq_en = v[0];
    m_en = v[1];
    if (!m_en) m_ref = 0;
  endtask

  task automatic model_w1c(input logic [31:0] v);
    if (v[1]) m_new = 0;
    if (v[2]) m_range = 0;
    if (v[3]) m_lost = 0;
  endtask

  // Each rise closes the previous pulse: width and period are whole ticks of elapsed cycles.
  task automatic model_rise(input int now);
    int w, p;
    if (!m_en) return;
    if (m_ref && (now - m_rise_c) > TOUT * D) begin
      m_lost = 1; m_valid = 0; m_ref = 0;
    end
    if (m_ref) begin
      w = (m_fall_c - m_rise_c) / D;
      p = (now - m_rise_c) / D;
      if (w >= MINP && w <= MAXP) begin
        m_pulse = w; m_period = p; m_valid = 1; m_new = 1;
      end else begin
        m_range = 1;
      end
    end
    m_ref = 1; m_rise_c = now; m_fall_c = now;
  endtask

  task automatic model_fall(input int now);
    m_fall_c = now;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    logic [31:0] exp_st;
    exp_st = {28'd0, m_lost, m_range, m_new, m_valid};
    chk({tag, ".pulse_us"}, {16'd0, pulse_us}, m_pulse);
    chk({tag, ".pulse_valid"}, {31'd0, pulse_valid}, {31'd0, m_valid});
    chk({tag, ".irq"}, {31'd0, irq}, {31'd0, m_irq_en & (m_new | m_range | m_lost)});
    rd(2'd0, d); chk({tag, ".reg0"}, d, m_pulse);
    rd(2'd1, d); chk({tag, ".reg1"}, d, m_period);
    rd(2'd2, d); chk({tag, ".reg2"}, d, exp_st);
    last_status = d;
    rd(2'd3, d); chk({tag, ".reg3"}, d, {30'd0, m_en, m_irq_en});
    last_irq = irq;
  endtask

  // wmode 0: none, 1: W1C write landing on the commit edge, 2: W1C write at start of low phase.
  task automatic pulse(input int h, input int l, input int wmode, input logic [31:0] wval, input string tag);
    int t0;
    pwm_in = 1'b1;
    t0 = cyc;
    if (wmode == 1) model_w1c(wval);
    model_rise(t0);
    if (wmode == 1) begin
      repeat (3) @(negedge clk);
      wr(2'd2, wval);
      repeat (4) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    check_all(tag);
    repeat (h - 8) @(negedge clk);
    pwm_in = 1'b0;
    model_fall(cyc);
    if (wmode == 2) begin
      wr(2'd2, wval);
      model_w1c(wval);
      repeat (l - 1) @(negedge clk);
    end else begin
      repeat (l) @(negedge clk);
    end
  endtask

  initial begin
    #(150000 * 10);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [31:0] v;
    int h, l;
    tbl[0] = '{150, 250,   0,   0, 0};
    tbl[1] = '{ 50, 350, 150, 400, 3};
    tbl[2] = '{250, 150,  50, 400, 3};
    tbl[3] = '{251, 149, 250, 400, 3};
    tbl[4] = '{150, 250, 250, 400, 7};

    reset = 1'b1; pwm_in = 1'b0; address = 2'd0; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; writedata = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("reset");

    // Basic train with irq, W1C of new_sample
    wr(2'd3, 32'h3); model_ctrl(32'h3);
    pulse(150 * D, 250 * D, 0, 0, "t1.ref");
    pulse(150 * D, 250 * D, 0, 0, "t1.c1");
    chk("t1.status", last_status, 32'h3);
    chk("t1.irq_set", {31'd0, last_irq}, 32'h1);
    pulse(150 * D, 250 * D, 2, 32'h2, "t1.c2");
    chk("t1.irq_cleared", {31'd0, irq}, 32'h0);
    rd(2'd2, d); chk("t1.status_cleared", d, 32'h1);
    pulse(150 * D, 250 * D, 0, 0, "t1.c3");
    chk("t1.irq_reset", {31'd0, last_irq}, 32'h1);

    // Boundary widths from a fresh reset
    reset = 1'b1; @(negedge clk); @(negedge clk); reset = 1'b0; model_reset();
    for (int i = 0; i < 5; i++) begin
      pulse(tbl[i].high_us * D, tbl[i].low_us * D, 0, 0, $sformatf("t2.row%0d", i));
      rd(2'd0, d); chk($sformatf("t2.tbl_pulse%0d", i), d, tbl[i].exp_pulse);
      rd(2'd1, d); chk($sformatf("t2.tbl_period%0d", i), d, tbl[i].exp_period);
      chk($sformatf("t2.tbl_status%0d", i), last_status, tbl[i].exp_status);
    end

    // W1C of new_sample on the commit edge: set wins
    pulse(150 * D, 250 * D, 1, 32'h2, "t4.w1c_commit");
    chk("t4.new_sample_kept", {31'd0, last_status[1]}, 32'h1);

    // Signal loss while held high
    pwm_in = 1'b1;
    model_rise(cyc);
    repeat (TOUT * D - 20) @(negedge clk);
    rd(2'd2, d);
    chk("t3.not_lost_yet", {31'd0, d[3]}, 32'h0);
    chk("t3.valid_before", {31'd0, pulse_valid}, 32'h1);
    repeat (60) @(negedge clk);
    rd(2'd2, d);
    chk("t3.lost", {31'd0, d[3]}, 32'h1);
    chk("t3.valid_dropped", {31'd0, pulse_valid}, 32'h0);
    repeat (3000 * D - TOUT * D - 40) @(negedge clk);
    pwm_in = 1'b0;
    model_fall(cyc);
    repeat (250 * D) @(negedge clk);
    pulse(150 * D, 250 * D, 0, 0, "t3.ref");
    chk("t3.still_invalid", {31'd0, pulse_valid}, 32'h0);
    pulse(180 * D, 220 * D, 0, 0, "t3.restore");
    chk("t3.valid_restored", {31'd0, pulse_valid}, 32'h1);
    pulse(180 * D, 220 * D, 0, 0, "t3.next");

    // Reset in the middle of a high pulse
    wr(2'd3, 32'h3); model_ctrl(32'h3);
    pwm_in = 1'b1;
    model_rise(cyc);
    repeat (70 * D) @(negedge clk);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    model_reset();
    check_all("t5.after_reset");
    chk("t5.pulse_zero", {16'd0, pulse_us}, 32'h0);
    repeat (80 * D) @(negedge clk);
    pwm_in = 1'b0;
    model_fall(cyc);
    repeat (250 * D) @(negedge clk);
    pulse(150 * D, 250 * D, 0, 0, "t5.ref");
    chk("t5.no_commit", last_status, 32'h0);
    pulse(150 * D, 250 * D, 0, 0, "t5.commit");
    chk("t5.pulse", {16'd0, pulse_us}, 32'd150);

    // Capture disable/enable
    wr(2'd3, 32'h0); model_ctrl(32'h0);
    pulse(200 * D, 200 * D, 0, 0, "t6.off1");
    pulse(200 * D, 200 * D, 0, 0, "t6.off2");
    chk("t6.hold", {16'd0, pulse_us}, 32'd150);
    wr(2'd3, 32'h2); model_ctrl(32'h2);
    pulse(200 * D, 200 * D, 0, 0, "t6.on_ref");
    chk("t6.hold_ref", {16'd0, pulse_us}, 32'd150);
    pulse(200 * D, 200 * D, 0, 0, "t6.on_commit");
    chk("t6.resumed", {16'd0, pulse_us}, 32'd200);

    // Randomized trains against the reference model
    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(280 * D, 30 * D);
      l = $urandom_range(200 * D, 20 * D);
      if ($urandom_range(3, 0) == 0)
        pulse(h, l, 2, $urandom, $sformatf("rnd%0d", i));
      else
        pulse(h, l, 0, 0, $sformatf("rnd%0d", i));
      if ($urandom_range(4, 0) == 0) begin
        v = {30'd0, 1'b1, 1'($urandom_range(1, 0))};
        wr(2'd3, v);
        model_ctrl(v);
      end
    end
    check_all("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
